// File: rtl/block_scheduler_if.sv
// Host/datapath-side signal bundle for block_scheduler.
// drop_count_o exists only when BLOCK_SCHED_DROP_COUNT_EN is defined.
interface block_scheduler_if #(
  parameter int CNT_W = 16
);
  logic             run_i;
  logic             dc_valid_i;
  logic             goertzel_done_i;
  logic             en_o;
  logic             start_block_o;
  logic             busy_o;
  logic             block_done_o;
  logic [CNT_W-1:0] block_count_o;
  logic             timeout_err_o;
  logic [2:0]       state_o;
`ifdef BLOCK_SCHED_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_count_o;

  modport slave (
    input  run_i, dc_valid_i, goertzel_done_i,
    output en_o, start_block_o, busy_o, block_done_o, block_count_o,
           timeout_err_o, state_o, drop_count_o
  );
  modport master (
    output run_i, dc_valid_i, goertzel_done_i,
    input  en_o, start_block_o, busy_o, block_done_o, block_count_o,
           timeout_err_o, state_o, drop_count_o
  );
`else
  modport slave (
    input  run_i, dc_valid_i, goertzel_done_i,
    output en_o, start_block_o, busy_o, block_done_o, block_count_o,
           timeout_err_o, state_o
  );
  modport master (
    output run_i, dc_valid_i, goertzel_done_i,
    input  en_o, start_block_o, busy_o, block_done_o, block_count_o,
           timeout_err_o, state_o
  );
`endif
endinterface

// File: rtl/block_scheduler.sv
// Receiver sequencer: DC-blocker enable, settling, Goertzel block start/count/done with timeout.
// Optional dropped-sample counter enabled by defining BLOCK_SCHED_DROP_COUNT_EN.
module block_scheduler #(
  parameter int BLOCK_SIZE_POW2 = 15,
  parameter int SETTLE_SAMPLES  = 256,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int CNT_W           = 16
) (
  input logic              clk,
  input logic              rst,
  block_scheduler_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTLE    = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_ACCUM     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;

  localparam int SETTLE_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST =
    SETTLE_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]                 state_q, state_d;
  logic [SETTLE_W-1:0]        settle_cnt_q, settle_cnt_d;
  logic [BLOCK_SIZE_POW2-1:0] sample_cnt_q, sample_cnt_d;
  logic [TO_W-1:0]            wait_cnt_q, wait_cnt_d;
  logic                       en_q, en_d;
  logic                       start_q, start_d;
  logic                       block_done_q, block_done_d;
  logic [CNT_W-1:0]           block_count_q, block_count_d;
  logic                       timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    sample_cnt_d  = sample_cnt_q;
    wait_cnt_d    = '0;
    block_done_d  = 1'b0;
    block_count_d = block_count_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        settle_cnt_d = '0;
        if (bus.run_i) begin
          state_d = (SETTLE_SAMPLES > 0) ? ST_SETTLE : ST_START;
        end
      end
      ST_SETTLE: begin
        if (!bus.run_i) begin
          state_d = ST_IDLE;
        end else if (bus.dc_valid_i) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = ST_START;
          else settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        sample_cnt_d = '0;
        state_d      = bus.run_i ? ST_ACCUM : ST_IDLE;
      end
      ST_ACCUM: begin
        if (!bus.run_i) begin
          state_d = ST_IDLE;
        end else if (bus.dc_valid_i) begin
          if (sample_cnt_q == '1) state_d = ST_WAIT_DONE;
          else sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        // A done coincident with the timeout cycle counts as a normal completion.
        if (bus.goertzel_done_i) begin
          block_done_d  = 1'b1;
          block_count_d = block_count_q + 1'b1;
          state_d       = bus.run_i ? ST_START : ST_IDLE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = bus.run_i ? ST_START : ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    en_d    = (state_d != ST_IDLE);
    start_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      settle_cnt_q  <= '0;
      sample_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      en_q          <= 1'b0;
      start_q       <= 1'b0;
      block_done_q  <= 1'b0;
      block_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      sample_cnt_q  <= sample_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      en_q          <= en_d;
      start_q       <= start_d;
      block_done_q  <= block_done_d;
      block_count_q <= block_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.en_o          = en_q;
  assign bus.busy_o        = en_q;
  assign bus.start_block_o = start_q;
  assign bus.block_done_o  = block_done_q;
  assign bus.block_count_o = block_count_q;
  assign bus.timeout_err_o = timeout_err_q;
  assign bus.state_o       = state_q;

`ifdef BLOCK_SCHED_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Samples arriving while no block is accumulating are lost to the Goertzel.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.dc_valid_i && (state_q == ST_START || state_q == ST_WAIT_DONE) &&
        drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_block_scheduler.sv
// Directed self-checking bench for block_scheduler (BLOCK_SIZE_POW2=3, SETTLE=4, TIMEOUT=20).
module tb_block_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   start_pulses;
  int   settle_entries;
  int   idle_cycles;
  logic [2:0] prev_state;
  int   pulses0, settles0, idle0;

  block_scheduler_if #(.CNT_W(16)) bus ();

  block_scheduler #(
    .BLOCK_SIZE_POW2(3),
    .SETTLE_SAMPLES (4),
    .TIMEOUT_CYCLES (20),
    .CNT_W          (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampled on the falling edge, away from the active edge.
  initial begin
    start_pulses   = 0;
    settle_entries = 0;
    idle_cycles    = 0;
    prev_state     = 3'd0;
  end
  always @(negedge clk) begin
    if (bus.start_block_o === 1'b1) start_pulses++;
    if (bus.state_o === 3'd0) idle_cycles++;
    if (bus.state_o === 3'd1 && prev_state !== 3'd1) settle_entries++;
    prev_state = bus.state_o;
  end

  task automatic applyStimulus(input logic run, input logic valid, input logic done);
    bus.run_i           = run;
    bus.dc_valid_i      = valid;
    bus.goertzel_done_i = done;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // From START: one ACCUM entry cycle, 8 back-to-back strobes, then idle WAIT_DONE cycles.
  task automatic runBlock(input int wait_cycles);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("blk_accum_state", bus.state_o, 3);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("blk_wait_state", bus.state_o, 4);
    repeat (wait_cycles) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.run_i = 1'b0;
    bus.dc_valid_i = 1'b0;
    bus.goertzel_done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", bus.state_o, 0);
    checkOutput("rst_en", bus.en_o, 0);
    checkOutput("rst_busy", bus.busy_o, 0);
    checkOutput("rst_start", bus.start_block_o, 0);
    checkOutput("rst_done", bus.block_done_o, 0);
    checkOutput("rst_count", bus.block_count_o, 0);
    checkOutput("rst_timeout", bus.timeout_err_o, 0);
`ifdef BLOCK_SCHED_DROP_COUNT_EN
    checkOutput("rst_drop", bus.drop_count_o, 0);
`endif
    rst = 1'b0;
    pulses0  = start_pulses;
    settles0 = settle_entries;

    // Scenario 1: basic block, strobe every second cycle
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s1_settle_state", bus.state_o, 1);
    checkOutput("s1_en_rise", bus.en_o, 1);
    checkOutput("s1_busy", bus.busy_o, 1);
    idle0 = idle_cycles;
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("s1_settle_after3", bus.state_o, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s1_start_pulse", bus.start_block_o, 1);
    checkOutput("s1_start_state", bus.state_o, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s1_accum_state", bus.state_o, 3);
    checkOutput("s1_start_one_cycle", bus.start_block_o, 0);
    repeat (7) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("s1_accum_after7", bus.state_o, 3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s1_wait_state", bus.state_o, 4);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s1_no_early_done", bus.block_done_o, 0);
    checkOutput("s1_still_wait", bus.state_o, 4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("s1_block_done", bus.block_done_o, 1);
    checkOutput("s1_count", bus.block_count_o, 1);
    checkOutput("s1_restart", bus.state_o, 2);
    checkOutput("s1_timeout_clear", bus.timeout_err_o, 0);

    // Scenario 2: continuous operation for blocks 2 and 3
    runBlock(2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("s2_done2", bus.block_done_o, 1);
    checkOutput("s2_count2", bus.block_count_o, 2);
    checkOutput("s2_restart2", bus.state_o, 2);
    runBlock(3);
    checkOutput("s2_no_idle", idle_cycles - idle0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s2_done3", bus.block_done_o, 1);
    checkOutput("s2_count3", bus.block_count_o, 3);
    checkOutput("s2_idle_after", bus.state_o, 0);
    checkOutput("s2_start_pulses", start_pulses - pulses0, 3);
    checkOutput("s2_settle_once", settle_entries - settles0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s2_done_cleared", bus.block_done_o, 0);
    checkOutput("s2_en_low", bus.en_o, 0);
    checkOutput("s2_busy_low", bus.busy_o, 0);

    // Scenario 3: timeout, no done ever
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s3_settle", bus.state_o, 1);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s3_start", bus.state_o, 2);
    runBlock(19);
    checkOutput("s3_wait_19", bus.state_o, 4);
    checkOutput("s3_no_timeout_yet", bus.timeout_err_o, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s3_timeout", bus.timeout_err_o, 1);
    checkOutput("s3_no_done", bus.block_done_o, 0);
    checkOutput("s3_count_kept", bus.block_count_o, 3);
    checkOutput("s3_next_start", bus.start_block_o, 1);

    // Scenario 4: abort after 5 ACCUM strobes, then resettle
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s4_accum", bus.state_o, 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s4_idle", bus.state_o, 0);
    checkOutput("s4_en_low", bus.en_o, 0);
    checkOutput("s4_no_done", bus.block_done_o, 0);
    checkOutput("s4_timeout_sticky", bus.timeout_err_o, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s4_resettle_3", bus.state_o, 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s4_resettle_start", bus.state_o, 2);

    // Scenario 6: reset while in ACCUM
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s6_state", bus.state_o, 0);
    checkOutput("s6_en", bus.en_o, 0);
    checkOutput("s6_busy", bus.busy_o, 0);
    checkOutput("s6_start", bus.start_block_o, 0);
    checkOutput("s6_done", bus.block_done_o, 0);
    checkOutput("s6_count", bus.block_count_o, 0);
    checkOutput("s6_timeout", bus.timeout_err_o, 0);
    rst = 1'b0;

    // Scenario 5: done on the last WAIT_DONE cycle, plus dropped strobes
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s5_start", bus.state_o, 2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s5_accum", bus.state_o, 3);
    repeat (7) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("s5_start_strobe_uncounted", bus.state_o, 3);
    checkOutput("s5_done_ignored", bus.block_done_o, 0);
    checkOutput("s5_count_zero", bus.block_count_o, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("s5_wait", bus.state_o, 4);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, (i == 3 || i == 10), 1'b0);
    end
    checkOutput("s5_wait_19", bus.state_o, 4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("s5_block_done", bus.block_done_o, 1);
    checkOutput("s5_no_timeout", bus.timeout_err_o, 0);
    checkOutput("s5_count", bus.block_count_o, 1);
`ifdef BLOCK_SCHED_DROP_COUNT_EN
    checkOutput("s5_drop_count", bus.drop_count_o, 3);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s5_abort_start", bus.state_o, 0);
    checkOutput("s5_timeout_final", bus.timeout_err_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
